// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: paces instructions by prescaled tick (run) or step edge, one-hot stage strobes.
// Latency: fetch_en +1 after start, 4-5 busy cycles; ticks/steps arriving while busy or halted are dropped.
module core_sequencer #(
    parameter int TICK_DIV = 8388608
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        run,
    input  logic        step,
    input  logic        halt_req,
    input  logic        clear,
    input  logic [3:0]  opcode,
    input  logic        c_zero,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        wb_en,
    output logic        pc_inc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  presc;
    logic           tick;
    logic           step_d;
    logic           step_edge;
    logic           start;
    logic           div_zero;
    logic           is_mem;

    assign tick      = (presc == TICK_LAST);
    assign step_edge = step & ~step_d;
    // run has priority: a step edge while running is ignored
    assign start     = run ? tick : step_edge;
    assign div_zero  = ((opcode == 4'd7) || (opcode == 4'd8)) && c_zero;
    assign is_mem    = (opcode == 4'd1) || (opcode == 4'd2);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc  <= '0;
            step_d <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            step_d <= step;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (halt_req) begin
                    state_nx = S_HALT;
                end else if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXECUTE;
            S_EXECUTE: begin
                if (div_zero) begin
                    state_nx = S_HALT;
                end else if (is_mem) begin
                    state_nx = S_MEMORY;
                end else begin
                    state_nx = S_WRITEBACK;
                end
            end
            // mem_rd is still high here for a load, so it selects the load path
            S_MEMORY: begin
                if (mem_rd) begin
                    state_nx = S_WRITEBACK;
                end else begin
                    state_nx = halt_req ? S_HALT : S_IDLE;
                end
            end
            S_WRITEBACK: state_nx = halt_req ? S_HALT : S_IDLE;
            S_HALT: begin
                if (clear) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            wb_en     <= 1'b0;
            pc_inc    <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            retired   <= 16'd0;
        end else begin
            fetch_en  <= (state_nx == S_FETCH);
            decode_en <= (state_nx == S_DECODE);
            exec_en   <= (state_nx == S_EXECUTE);
            mem_rd    <= (state_nx == S_MEMORY) && (opcode == 4'd1);
            mem_wr    <= (state_nx == S_MEMORY) && (opcode == 4'd2);
            wb_en     <= (state_nx == S_WRITEBACK);
            pc_inc    <= (state_nx == S_WRITEBACK) ||
                         ((state_nx == S_MEMORY) && (opcode == 4'd2));
            busy      <= (state_nx != S_IDLE) && (state_nx != S_HALT);
            halted    <= (state_nx == S_HALT);
            if ((state == S_EXECUTE) && div_zero) begin
                fault <= 1'b1;
            end else if ((state == S_HALT) && clear) begin
                fault <= 1'b0;
            end
            // pc_inc is high exactly in the final cycle of every completed instruction
            retired   <= retired + {15'd0, pc_inc};
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against a per-instruction strobe-schedule model.
module tb_core_sequencer;

    localparam int TICK_DIV = 8;
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_HALT = 2;

    // strobe vector order: fetch, decode, exec, mem_rd, mem_wr, wb, pc_inc
    localparam logic [6:0] V_F  = 7'b1000000;
    localparam logic [6:0] V_D  = 7'b0100000;
    localparam logic [6:0] V_E  = 7'b0010000;
    localparam logic [6:0] V_MR = 7'b0001000;
    localparam logic [6:0] V_MW = 7'b0000101;
    localparam logic [6:0] V_WB = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        c_zero = 1'b0;
    logic        fetch_en, decode_en, exec_en, mem_rd, mem_wr, wb_en, pc_inc;
    logic        busy, halted, fault;
    logic [15:0] retired;

    int total = 0;
    int bad = 0;

    int          m_cnt;
    logic        m_step_d;
    int          m_mode;
    logic        m_fault;
    logic        m_fault_pend;
    logic [15:0] m_ret;
    logic [6:0]  m_exp;
    logic [6:0]  m_q[$];

    core_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .run      (run),
        .step     (step),
        .halt_req (halt_req),
        .clear    (clear),
        .opcode   (opcode),
        .c_zero   (c_zero),
        .fetch_en (fetch_en),
        .decode_en(decode_en),
        .exec_en  (exec_en),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .wb_en    (wb_en),
        .pc_inc   (pc_inc),
        .busy     (busy),
        .halted   (halted),
        .fault    (fault),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_step_d = 1'b0;
        m_mode = M_IDLE;
        m_fault = 1'b0;
        m_fault_pend = 1'b0;
        m_ret = 16'd0;
        m_exp = 7'd0;
        m_q.delete();
    endtask

    // Whole-instruction schedule, built from the opcode held stable for the instruction.
    task automatic plan();
        m_q.delete();
        m_q.push_back(V_F);
        m_q.push_back(V_D);
        m_q.push_back(V_E);
        m_fault_pend = ((opcode == 4'd7) || (opcode == 4'd8)) && c_zero;
        if (!m_fault_pend) begin
            if (opcode == 4'd1) begin
                m_q.push_back(V_MR);
                m_q.push_back(V_WB);
            end else if (opcode == 4'd2) begin
                m_q.push_back(V_MW);
            end else begin
                m_q.push_back(V_WB);
            end
        end
    endtask

    task automatic model_edge();
        logic tk, edg;
        if (rst) begin
            model_reset();
            return;
        end
        tk = (m_cnt == TICK_DIV - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        edg = step && !m_step_d;
        m_step_d = step;
        case (m_mode)
            M_BUSY: begin
                if (m_q.size() > 0) begin
                    m_exp = m_q.pop_front();
                end else begin
                    m_exp = 7'd0;
                    if (m_fault_pend) begin
                        m_mode = M_HALT;
                        m_fault = 1'b1;
                    end else begin
                        m_ret = m_ret + 16'd1;
                        m_mode = halt_req ? M_HALT : M_IDLE;
                    end
                end
            end
            M_IDLE: begin
                if (halt_req) begin
                    m_mode = M_HALT;
                end else if (run ? tk : edg) begin
                    plan();
                    m_mode = M_BUSY;
                    m_exp = m_q.pop_front();
                end
            end
            default: begin
                if (clear) begin
                    m_mode = M_IDLE;
                    m_fault = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("strobes", 32'({fetch_en, decode_en, exec_en, mem_rd, mem_wr, wb_en, pc_inc}), 32'(m_exp));
        chk("busy", 32'(busy), 32'(m_mode == M_BUSY));
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("retired", 32'(retired), 32'(m_ret));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic step_pulse();
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_mode != M_IDLE && n < 50) begin
            cycle();
            n++;
        end
        if (m_mode != M_IDLE) chk("idle_timeout", 32'(m_mode), 32'(M_IDLE));
    endtask

    initial begin
        // reset state
        model_reset();
        #1;
        check_all();
        repeat (2) cycle();
        rst = 1'b0;

        // free-run: tick every 8 cycles, 10 instructions retire by edge 85
        opcode = 4'd4;
        run = 1'b1;
        repeat (85) cycle();
        run = 1'b0;
        chk("run10_retired", 32'(retired), 32'd10);
        wait_idle();

        // second step edge while busy is dropped
        step = 1'b1; cycle();
        step = 1'b0; cycle();
        step = 1'b1; cycle();
        step = 1'b0;
        wait_idle();
        chk("step_drop_retired", 32'(retired), 32'd11);
        step_pulse();
        wait_idle();
        chk("step_third_retired", 32'(retired), 32'd12);

        // load then store
        opcode = 4'd1;
        step_pulse();
        wait_idle();
        opcode = 4'd2;
        step_pulse();
        wait_idle();
        chk("ldst_retired", 32'(retired), 32'd14);

        // divide by zero faults into HALT; ticks ignored until clear
        opcode = 4'd7;
        c_zero = 1'b1;
        step_pulse();
        repeat (4) cycle();
        chk("dz_halted", 32'(halted), 32'd1);
        chk("dz_fault", 32'(fault), 32'd1);
        chk("dz_retired", 32'(retired), 32'd14);
        run = 1'b1;
        repeat (20) cycle();
        chk("dz_ticks_ignored", 32'(retired), 32'd14);
        c_zero = 1'b0;
        opcode = 4'd4;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clear_fault", 32'(fault), 32'd0);
        repeat (20) cycle();
        run = 1'b0;
        wait_idle();

        // halt_req raised in DECODE: writeback still happens, then HALT
        step = 1'b1; cycle();
        step = 1'b0; cycle();
        chk("decode_phase", 32'(decode_en), 32'd1);
        halt_req = 1'b1;
        repeat (3) cycle();
        chk("halt_after_wb", 32'(halted), 32'd1);
        // clear together with halt_req: IDLE for one cycle, then HALT again
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        halt_req = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();

        // reset during EXECUTE clears everything at once
        opcode = 4'd4;
        step = 1'b1; cycle();
        step = 1'b0; cycle();
        cycle();
        chk("exec_phase", 32'(exec_en), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        rst = 1'b0;
        cycle();

        // retired wraps 0xFFFF -> 0x0000
        force dut.retired = 16'hFFFE;
        m_ret = 16'hFFFE;
        cycle();
        release dut.retired;
        step_pulse();
        wait_idle();
        step_pulse();
        wait_idle();
        chk("wrap_retired", 32'(retired), 32'd0);

        // random mix of run/step/halt/clear with random opcodes
        for (int i = 0; i < 3000; i++) begin
            if (m_mode != M_BUSY) begin
                opcode = 4'($urandom_range(0, 15));
                c_zero = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 39) == 0) run = ~run;
            step = ($urandom_range(0, 2) == 0);
            halt_req = ($urandom_range(0, 30) == 0);
            clear = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
